// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, trap entry/return and a small
// circular return-address stack for call/return redirects.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              STEP      = 1,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h10,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         sel_next_pc_alu_out,
    input  logic [XLEN-1:0]              alu_out,
    input  logic                         trap,
    input  logic                         mret,
    input  logic                         ras_push,
    input  logic                         ras_pop,
    output logic [XLEN-1:0]              pc_out,
    output logic [XLEN-1:0]              pc_plus_step,
    output logic [XLEN-1:0]              epc_out,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_overflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] next_pc;
    logic            pop_valid;

    assign pc_plus_step = pc_out + XLEN'(STEP);
    assign ras_empty    = (ras_count == '0);
    assign ras_full     = (ras_count == CW'(RAS_DEPTH));
    assign ras_top      = ras_mem[ras_ptr];
    assign pop_valid    = ras_pop && !ras_empty;

    // Redirect choice for the non-trap, non-stall case; trap and stall are
    // resolved in the register block because they also gate the RAS.
    always_comb begin
        next_pc = pc_plus_step;
        if (mret) begin
            next_pc = epc_out;
        end else if (pop_valid) begin
            next_pc = ras_top;
        end else if (ras_pop || sel_next_pc_alu_out) begin
            next_pc = alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out       <= RESET_PC;
            epc_out      <= '0;
            ras_ptr      <= '0;
            ras_count    <= '0;
            ras_overflow <= 1'b0;
        end else if (trap) begin
            pc_out  <= TRAP_VEC;
            epc_out <= pc_out;
        end else if (!stall) begin
            pc_out <= next_pc;
            if (ras_push && pop_valid) begin
                ras_mem[ras_ptr] <= pc_plus_step;
            end else if (ras_push) begin
                // When full the slot after the top is the oldest entry, so
                // advancing the pointer overwrites it naturally.
                ras_mem[ras_ptr + 1'b1] <= pc_plus_step;
                ras_ptr                 <= ras_ptr + 1'b1;
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + 1'b1;
                end
            end else if (pop_valid) begin
                ras_ptr   <= ras_ptr - 1'b1;
                ras_count <= ras_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model predicts each cycle's
// outputs, which are queued at drive time and compared after the clock edge.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        sel_next_pc_alu_out;
    logic [31:0] alu_out;
    logic        trap;
    logic        mret;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_step;
    logic [31:0] epc_out;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;

    pc_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .sel_next_pc_alu_out (sel_next_pc_alu_out),
        .alu_out             (alu_out),
        .trap                (trap),
        .mret                (mret),
        .ras_push            (ras_push),
        .ras_pop             (ras_pop),
        .pc_out              (pc_out),
        .pc_plus_step        (pc_plus_step),
        .epc_out             (epc_out),
        .ras_count           (ras_count),
        .ras_empty           (ras_empty),
        .ras_full            (ras_full),
        .ras_overflow        (ras_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pps;
        logic [31:0] epc;
        logic [31:0] count;
        logic        empty;
        logic        full;
        logic        ovf;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    // Reference model: the stack is a plain list, newest entry at the back.
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_epc = 32'h0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_stack [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic tr, input logic st,
                                 input logic mr, input logic pu, input logic po,
                                 input logic sl, input logic [31:0] alu);
        logic [31:0] nxt;
        logic [31:0] pps;
        exp_t        e;
        rst = r; trap = tr; stall = st; mret = mr;
        ras_push = pu; ras_pop = po; sel_next_pc_alu_out = sl; alu_out = alu;
        pps = m_pc + 32'd1;
        if (r) begin
            m_pc = 32'h0;
            m_epc = 32'h0;
            m_ovf = 1'b0;
            m_stack.delete();
        end else if (tr) begin
            m_epc = m_pc;
            m_pc  = 32'h10;
        end else if (!st) begin
            if (mr)                         nxt = m_epc;
            else if (po && m_stack.size() > 0) nxt = m_stack[m_stack.size()-1];
            else if (po || sl)              nxt = alu;
            else                            nxt = pps;
            if (pu && po && m_stack.size() > 0) begin
                m_stack[m_stack.size()-1] = pps;
            end else if (pu) begin
                if (m_stack.size() == 4) begin
                    m_stack.delete(0);
                    m_ovf = 1'b1;
                end
                m_stack.push_back(pps);
            end else if (po && m_stack.size() > 0) begin
                void'(m_stack.pop_back());
            end
            m_pc = nxt;
        end
        e.pc    = m_pc;
        e.pps   = m_pc + 32'd1;
        e.epc   = m_epc;
        e.count = m_stack.size();
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == 4);
        e.ovf   = m_ovf;
        sb.push_back(e);
    endtask

    task automatic checkCycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("pc_out",       pc_out,              e.pc);
            checkOutput("pc_plus_step", pc_plus_step,        e.pps);
            checkOutput("epc_out",      epc_out,             e.epc);
            checkOutput("ras_count",    32'(ras_count),      e.count);
            checkOutput("ras_empty",    32'(ras_empty),      32'(e.empty));
            checkOutput("ras_full",     32'(ras_full),       32'(e.full));
            checkOutput("ras_overflow", 32'(ras_overflow),   32'(e.ovf));
        end
    endtask

    // Arguments: rst, trap, stall, mret, push, pop, sel, alu_out
    task automatic step(input logic r, input logic tr, input logic st,
                        input logic mr, input logic pu, input logic po,
                        input logic sl, input logic [31:0] alu);
        applyStimulus(r, tr, st, mr, pu, po, sl, alu);
        checkCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; trap = 1'b0; stall = 1'b0; mret = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0; sel_next_pc_alu_out = 1'b0;
        alu_out = 32'h0;

        $display("[TB] reset and free-running");
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 1, 1, 1, 1, 32'h55);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 32'h0);

        $display("[TB] stall over a pending redirect");
        step(0, 0, 0, 0, 0, 0, 1, 32'h5);
        step(0, 0, 1, 0, 0, 0, 1, 32'h40);
        step(0, 0, 1, 0, 0, 0, 1, 32'h40);
        step(0, 0, 0, 0, 0, 0, 1, 32'h40);

        $display("[TB] trap under stall, then mret");
        step(0, 0, 0, 0, 0, 0, 1, 32'h22);
        step(0, 1, 1, 1, 1, 1, 1, 32'h99);
        step(0, 0, 0, 1, 0, 0, 0, 32'h0);

        $display("[TB] call/return through the RAS");
        step(0, 0, 0, 0, 0, 0, 1, 32'h08);
        step(0, 0, 0, 0, 1, 0, 1, 32'h20);
        step(0, 0, 0, 0, 1, 0, 1, 32'h30);
        step(0, 0, 0, 0, 1, 0, 1, 32'h40);
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h77);

        $display("[TB] overflow wraps the oldest entry");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 0, 1, 32'h100 + 32'(i) * 32'h10);
        end
        repeat (4) step(0, 0, 0, 0, 0, 1, 0, 32'h0);

        $display("[TB] simultaneous push/pop and mid-sequence reset");
        step(0, 0, 0, 0, 0, 0, 1, 32'h4F);
        step(0, 0, 0, 0, 1, 0, 1, 32'h60);
        step(0, 0, 0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 1, 1, 1, 32'h33);
        step(0, 0, 0, 0, 1, 0, 1, 32'h70);
        step(1, 0, 0, 0, 1, 1, 1, 32'h70);
        step(0, 0, 0, 1, 1, 1, 0, 32'h12);

        $display("[TB] randomised mix");
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0,  $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0,  $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,  $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit, the next generation of the fetch-stage PC register.
- Adds configurable width, increment step and reset vector, pipeline stall, trap entry/return with a saved EPC, and a small return-address stack (RAS) for call/return redirects.
- Sits at the head of the fetch stage. Drives instruction-memory addressing and supplies the link value to the writeback mux.

Parameters:
- XLEN, 32, width of all PC-related datapaths.
- RESET_PC, 0, value loaded into pc_out on reset.
- STEP, 1, sequential increment (1 = instruction indexing, 4 = byte addressing).
- TRAP_VEC, 32'h0000_0010, fixed trap handler address (XLEN bits).
- RAS_DEPTH, 4, RAS entry count; power of two, at least 2.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold PC and block non-trap updates
- sel_next_pc_alu_out  in  1  jump/branch-taken redirect to alu_out
- alu_out  in  XLEN  computed branch/jump target
- trap  in  1  take trap this cycle
- mret  in  1  return from trap to EPC
- ras_push  in  1  call: push pc_plus_step onto RAS
- ras_pop  in  1  return: redirect to RAS top
- pc_out  out  XLEN  current PC
- pc_plus_step  out  XLEN  pc_out + STEP, combinational
- epc_out  out  XLEN  saved exception PC
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty  out  1  ras_count == 0
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_overflow  out  1  sticky; set when a push occurs while full

Behaviour:
Reset:
- On a rising edge with rst=1: pc_out=RESET_PC, epc_out=0, ras_count=0, RAS pointer=0, ras_overflow=0.
- rst overrides every other input. Reset mid-operation discards RAS contents and any pending redirect.

Arithmetic:
- pc_plus_step = pc_out + STEP, truncated to XLEN bits.
- Wraps silently: all-ones + 1 gives 0.

next_pc priority, evaluated each cycle with 1-cycle latency to pc_out:
1. trap=1: next_pc=TRAP_VEC; epc_out<=pc_out. Takes effect even when stall=1. All other inputs are ignored that cycle, including RAS ops and mret.
2. stall=1: next_pc=pc_out. No RAS, EPC or overflow update.
3. mret=1: next_pc=epc_out.
4. ras_pop=1 and ras_empty=0: next_pc = RAS top entry.
5. ras_pop=1 and ras_empty=1: next_pc=alu_out (fallback target); RAS unchanged.
6. sel_next_pc_alu_out=1: next_pc=alu_out.
7. Otherwise: next_pc=pc_plus_step.

RAS:
- Circular buffer with a top pointer. Updated only under priorities 3–7, i.e. not on trap or stall.
- Push only: write pc_plus_step at pointer+1 (mod RAS_DEPTH), advance the pointer, count++.
- Push while full: overwrite the oldest entry, count stays RAS_DEPTH, set ras_overflow.
- Pop only, non-empty: pointer-- (mod RAS_DEPTH), count--.
- Push and pop together, non-empty: redirect uses the old top; the top entry is replaced with pc_plus_step; pointer and count are unchanged.
- Push and pop together, empty: redirect to alu_out; behaves as a push (count becomes 1).
- mret plus RAS ops in the same cycle: the RAS ops still update the stack; mret wins the redirect.
- ras_empty and ras_full are combinational from ras_count.

Test Plan:
- Reset, then 3 free-running cycles with STEP=1, RESET_PC=0 -> pc_out 0,1,2,3; pc_plus_step tracks pc_out+1; all RAS flags low except ras_empty=1.
- pc_out=5, sel_next_pc_alu_out=1, alu_out=0x40, stall=1 for 2 cycles, then stall=0 -> pc_out holds 5 for both stalled cycles, then becomes 0x40.
- pc_out=0x22 with stall=1 and trap=1 -> next pc_out=0x10, epc_out=0x22. Then mret=1 -> pc_out=0x22.
- Push at pc_out=0x08, 0x20, 0x30 (return addresses 0x09, 0x21, 0x31), then 3 pops -> pc_out 0x31, 0x21, 0x09; ras_count 3->0; a 4th pop with alu_out=0x77 -> pc_out=0x77, ras_count stays 0.
- RAS_DEPTH=4, 5 pushes of addresses A1..A5 -> ras_full=1, ras_overflow=1, count=4; 4 pops return A5, A4, A3, A2.
- Simultaneous push and pop with top=0x50 at pc_out=0x60 -> pc_out=0x50, top becomes 0x61, count unchanged. rst asserted mid-sequence -> pc_out=RESET_PC, ras_count=0, ras_overflow=0.
